// File: rtl/disp_pack_fifo.sv
// rtl/disp_pack_fifo.sv - width-converting display FIFO: packs RATIO narrow words per entry
module disp_pack_fifo #(
  parameter int IN_W     = 8,
  parameter int RATIO    = 2,
  parameter int DEPTH    = 512,
  parameter int ORDER    = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IN_W-1:0]             di,
  input  logic                        we,
  input  logic                        re,
  input  logic                        flush,
  output logic [IN_W*RATIO-1:0]       dout,
  output logic                        do_valid,
  output logic                        empty_flag,
  output logic                        full_flag,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [$clog2(DEPTH+1)-1:0]  word_cnt,
  output logic                        pack_pending,
  output logic                        overflow,
  output logic                        underflow
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int LW    = $clog2(RATIO);

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [LW-1:0]    lane_cnt;
  logic [OUT_W-1:0] pack, pack_next;
  logic             wr_ok, rd_ok, push;

  assign empty_flag   = (word_cnt == '0);
  assign full_flag    = (int'(word_cnt) == DEPTH);
  assign almost_empty = (int'(word_cnt) <= AE_LEVEL);
  assign almost_full  = (int'(word_cnt) >= AF_LEVEL);
  assign pack_pending = (lane_cnt != '0);

  assign wr_ok = we & ~full_flag & ~flush;
  assign rd_ok = re & ~empty_flag & ~flush;
  assign push  = wr_ok & (lane_cnt == LW'(RATIO - 1));

  // Merge the incoming lane into the partial word so the completing write can go straight to memory.
  always_comb begin
    pack_next = pack;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_cnt == LW'(k))
        pack_next[((ORDER != 0) ? k * IN_W : (RATIO - 1 - k) * IN_W) +: IN_W] = di;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= pack_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      lane_cnt  <= '0;
      pack      <= '0;
      word_cnt  <= '0;
      dout      <= '0;
      do_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      lane_cnt <= '0;
      word_cnt <= '0;
      do_valid <= 1'b0;
    end else begin
      do_valid <= rd_ok;
      if (we & full_flag)
        overflow <= 1'b1;
      if (re & empty_flag)
        underflow <= 1'b1;
      if (wr_ok) begin
        pack     <= pack_next;
        lane_cnt <= push ? '0 : lane_cnt + LW'(1);
      end
      if (push)
        wptr <= wptr + AW'(1);
      if (rd_ok) begin
        dout <= mem[rptr];
        rptr <= rptr + AW'(1);
      end
      case ({push, rd_ok})
        2'b10:   word_cnt <= word_cnt + CW'(1);
        2'b01:   word_cnt <= word_cnt - CW'(1);
        default: word_cnt <= word_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_disp_pack_fifo.sv
// tb/tb_disp_pack_fifo.sv - randomized and directed bench for disp_pack_fifo against a queue model
module tb_disp_pack_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       we_s [2];
  logic       re_s [2];
  logic       fl_s [2];
  logic [7:0] di_s [2];

  logic [15:0] dout0;
  logic [11:0] dout1;
  logic        dv0, dv1, em0, em1, fu0, fu1, ae0, ae1, af0, af1, pp0, pp1, ov0, ov1, un0, un1;
  logic [2:0]  cnt0, cnt1;

  disp_pack_fifo #(.IN_W(8), .RATIO(2), .DEPTH(4), .ORDER(0), .AF_LEVEL(3), .AE_LEVEL(1)) u0 (
    .clk(clk), .rst(rst), .di(di_s[0]), .we(we_s[0]), .re(re_s[0]), .flush(fl_s[0]),
    .dout(dout0), .do_valid(dv0), .empty_flag(em0), .full_flag(fu0), .almost_empty(ae0),
    .almost_full(af0), .word_cnt(cnt0), .pack_pending(pp0), .overflow(ov0), .underflow(un0));

  disp_pack_fifo #(.IN_W(4), .RATIO(3), .DEPTH(4), .ORDER(1), .AF_LEVEL(3), .AE_LEVEL(1)) u1 (
    .clk(clk), .rst(rst), .di(di_s[1][3:0]), .we(we_s[1]), .re(re_s[1]), .flush(fl_s[1]),
    .dout(dout1), .do_valid(dv1), .empty_flag(em1), .full_flag(fu1), .almost_empty(ae1),
    .almost_full(af1), .word_cnt(cnt1), .pack_pending(pp1), .overflow(ov1), .underflow(un1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of packed words plus the list of narrow words awaiting packing.
  int unsigned mq [2][$];
  int unsigned mp [2][$];
  bit          mov [2];
  bit          mun [2];
  bit          mdv [2];
  int unsigned mdo [2];
  int          cfg_w [2] = '{8, 4};
  int          cfg_r [2] = '{2, 3};
  int          cfg_o [2] = '{0, 1};

  task automatic model_step(input int i, input bit w, input bit r, input bit f, input int unsigned d);
    bit          was_full, was_empty;
    int unsigned word;
    int          lo;
    was_full  = (mq[i].size() == 4);
    was_empty = (mq[i].size() == 0);
    if (rst) begin
      mq[i].delete(); mp[i].delete();
      mov[i] = 0; mun[i] = 0; mdv[i] = 0; mdo[i] = 0;
    end else if (f) begin
      mq[i].delete(); mp[i].delete();
      mdv[i] = 0;
    end else begin
      mdv[i] = 0;
      if (r) begin
        if (was_empty) mun[i] = 1;
        else begin
          mdo[i] = mq[i].pop_front();
          mdv[i] = 1;
        end
      end
      if (w) begin
        if (was_full) mov[i] = 1;
        else begin
          mp[i].push_back(d);
          if (mp[i].size() == cfg_r[i]) begin
            word = 0;
            for (int k = 0; k < cfg_r[i]; k++) begin
              lo = (cfg_o[i] != 0) ? k * cfg_w[i] : (cfg_r[i] - 1 - k) * cfg_w[i];
              word |= mp[i][k] << lo;
            end
            mq[i].push_back(word);
            mp[i].delete();
          end
        end
      end
    end
  endtask

  task automatic cmp_inst(input int i, input logic [31:0] g_do, input logic g_dv, input logic g_em,
                          input logic g_fu, input logic g_ae, input logic g_af, input logic [31:0] g_cnt,
                          input logic g_pp, input logic g_ov, input logic g_un);
    int n;
    n = mq[i].size();
    chk($sformatf("dout%0d", i), g_do, mdo[i]);
    chk($sformatf("do_valid%0d", i), 32'(g_dv), 32'(mdv[i]));
    chk($sformatf("word_cnt%0d", i), g_cnt, n);
    chk($sformatf("empty%0d", i), 32'(g_em), 32'(n == 0));
    chk($sformatf("full%0d", i), 32'(g_fu), 32'(n == 4));
    chk($sformatf("almost_empty%0d", i), 32'(g_ae), 32'(n <= 1));
    chk($sformatf("almost_full%0d", i), 32'(g_af), 32'(n >= 3));
    chk($sformatf("pack_pending%0d", i), 32'(g_pp), 32'(mp[i].size() != 0));
    chk($sformatf("overflow%0d", i), 32'(g_ov), 32'(mov[i]));
    chk($sformatf("underflow%0d", i), 32'(g_un), 32'(mun[i]));
  endtask

  task automatic step();
    model_step(0, we_s[0], re_s[0], fl_s[0], di_s[0]);
    model_step(1, we_s[1], re_s[1], fl_s[1], di_s[1] & 8'h0f);
    @(posedge clk);
    #1;
    cmp_inst(0, dout0, dv0, em0, fu0, ae0, af0, cnt0, pp0, ov0, un0);
    cmp_inst(1, dout1, dv1, em1, fu1, ae1, af1, cnt1, pp1, ov1, un1);
    for (int i = 0; i < 2; i++) begin
      we_s[i] = 0; re_s[i] = 0; fl_s[i] = 0; di_s[i] = '0;
    end
  endtask

  task automatic drive(input int i, input bit w, input bit r, input bit f, input logic [7:0] d);
    we_s[i] = w; re_s[i] = r; fl_s[i] = f; di_s[i] = d;
  endtask

  logic [15:0] exp_rd [4] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607};

  initial begin
    for (int i = 0; i < 2; i++) drive(i, 0, 0, 0, 8'h00);
    rst = 1;
    step();
    step();
    rst = 0;
    chk("reset_empty", 32'(em0), 1);
    chk("reset_full", 32'(fu0), 0);
    chk("reset_cnt", 32'(cnt0), 0);

    // Lane order, ORDER=0
    drive(0, 1, 0, 0, 8'hA5); step();
    drive(0, 1, 0, 0, 8'h3C); step();
    drive(0, 0, 1, 0, 8'h00); step();
    chk("order0_dout", 32'(dout0), 32'h A53C);
    chk("order0_valid", 32'(dv0), 1);
    chk("order0_empty", 32'(em0), 1);

    // Fill to full, overflow, drain
    for (int b = 0; b < 8; b++) begin
      drive(0, 1, 0, 0, 8'(b)); step();
    end
    chk("fill_full", 32'(fu0), 1);
    chk("fill_cnt", 32'(cnt0), 4);
    chk("fill_af", 32'(af0), 1);
    drive(0, 1, 0, 0, 8'h08); step();
    chk("ovf_flag", 32'(ov0), 1);
    chk("ovf_pending", 32'(pp0), 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 0, 8'h00); step();
      chk($sformatf("drain%0d", k), 32'(dout0), 32'(exp_rd[k]));
    end
    chk("drain_empty", 32'(em0), 1);

    // Read while empty
    drive(0, 0, 1, 0, 8'h00); step();
    chk("unf_flag", 32'(un0), 1);
    chk("unf_dout", 32'(dout0), 32'h0607);
    chk("unf_valid", 32'(dv0), 0);
    chk("unf_cnt", 32'(cnt0), 0);

    // Streaming at constant occupancy across pointer wrap
    for (int b = 0; b < 4; b++) begin
      drive(0, 1, 0, 0, 8'(8'h40 + b)); step();
    end
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 0, 0, 8'(8'h80 + 2 * k)); step();
      drive(0, 1, 1, 0, 8'(8'h81 + 2 * k)); step();
      chk($sformatf("stream_cnt%0d", k), 32'(cnt0), 2);
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, 0, 8'h00); step();
    end

    // Flush discards a partial word
    drive(0, 1, 0, 0, 8'h77); step();
    chk("flush_pend_before", 32'(pp0), 1);
    drive(0, 1, 1, 1, 8'h99); step();
    drive(0, 1, 0, 0, 8'h11); step();
    drive(0, 1, 0, 0, 8'h22); step();
    drive(0, 0, 1, 0, 8'h00); step();
    chk("flush_dout", 32'(dout0), 32'h1122);
    chk("flush_pend_after", 32'(pp0), 0);
    chk("flush_ovf_kept", 32'(ov0), 1);

    // Reset discards a partial word and clears sticky flags
    drive(0, 1, 0, 0, 8'h77); step();
    rst = 1; step(); rst = 0;
    drive(0, 1, 0, 0, 8'h11); step();
    drive(0, 1, 0, 0, 8'h22); step();
    drive(0, 0, 1, 0, 8'h00); step();
    chk("rst_dout", 32'(dout0), 32'h1122);
    chk("rst_ovf", 32'(ov0), 0);
    chk("rst_unf", 32'(un0), 0);

    // RATIO=3, IN_W=4, ORDER=1
    drive(1, 1, 0, 0, 8'h1); step();
    drive(1, 1, 0, 0, 8'h2); step();
    drive(1, 1, 0, 0, 8'h3); step();
    drive(1, 0, 1, 0, 8'h0); step();
    chk("r3_dout", 32'(dout1), 32'h321);

    // Random traffic on both instances
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 2; i++)
        drive(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 63) == 0),
              8'($urandom));
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
